// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transceiver.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Data is zero-extended to 9 bits, which leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: ticks once every CLKS_PER_BIT cycles, loadable to a full or half period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_half,
  output logic o_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset)              r_cnt <= FULL_LOAD;
    else if (i_load)         r_cnt <= i_half ? HALF_LOAD : FULL_LOAD;
    else if (r_cnt == '0)    r_cnt <= FULL_LOAD;
    else                     r_cnt <= r_cnt - 1'b1;
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART with tx valid/ready handshake and synchronised mid-bit rx sampling.
// Optional internal loopback port enabled by defining UART_LOOPBACK_EN.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           i_parity_mode,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  input  logic                 i_rx,
`ifdef UART_LOOPBACK_EN
  input  logic                 i_loopback,
`endif
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err
);

  if (CLKS_PER_BIT < 4)                 begin : g_bad_clks  $error("CLKS_PER_BIT must be >= 4"); end
  if (DATA_BITS < 5 || DATA_BITS > 9)   begin : g_bad_data  $error("DATA_BITS must be 5..9"); end
  if (STOP_BITS < 1 || STOP_BITS > 2)   begin : g_bad_stop  $error("STOP_BITS must be 1 or 2"); end
  if (SYNC_STAGES < 2)                  begin : g_bad_sync  $error("SYNC_STAGES must be >= 2"); end

  // ---------------- transmit path ----------------
  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic [3:0]           r_tx_bit_cnt;
  logic [1:0]           r_tx_stop_cnt;
  logic                 r_tx_par_en, r_tx_par_bit, r_tx;
  logic                 w_tx_tick, w_tx_last_stop, w_tx_ready, w_tx_hs, w_tx_line_nxt;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
    .clk(clk), .reset(reset), .i_load(w_tx_hs), .i_half(1'b0), .o_tick(w_tx_tick)
  );

  assign w_tx_last_stop = (r_tx_state == TX_STOP) && w_tx_tick &&
                          (r_tx_stop_cnt == 2'(STOP_BITS - 1));
  assign w_tx_ready     = (r_tx_state == TX_IDLE) || w_tx_last_stop;
  assign w_tx_hs        = i_tx_valid && w_tx_ready;
  assign o_tx_ready     = w_tx_ready;

  always_ff @(posedge clk) begin
    if (!reset) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_state_nxt;
  end

  // The line is registered from the next state so tx never glitches on state decode.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_line_nxt  = 1'b1;
    unique case (r_tx_state)
      TX_IDLE:   if (w_tx_hs) w_tx_state_nxt = TX_START;
      TX_START:  if (w_tx_tick) w_tx_state_nxt = TX_DATA;
      TX_DATA:   if (w_tx_tick && r_tx_bit_cnt == 4'(DATA_BITS - 1))
                   w_tx_state_nxt = r_tx_par_en ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_tx_tick) w_tx_state_nxt = TX_STOP;
      TX_STOP:   if (w_tx_last_stop) w_tx_state_nxt = w_tx_hs ? TX_START : TX_IDLE;
      default:   w_tx_state_nxt = TX_IDLE;
    endcase
    unique case (w_tx_state_nxt)
      TX_START:  w_tx_line_nxt = 1'b0;
      TX_DATA:   w_tx_line_nxt = (r_tx_state == TX_DATA && w_tx_tick) ? r_tx_shift[1] : r_tx_shift[0];
      TX_PARITY: w_tx_line_nxt = r_tx_par_bit;
      default:   w_tx_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx          <= 1'b1;
      r_tx_shift    <= '0;
      r_tx_bit_cnt  <= '0;
      r_tx_stop_cnt <= '0;
      r_tx_par_en   <= 1'b0;
      r_tx_par_bit  <= 1'b0;
    end else begin
      r_tx <= w_tx_line_nxt;
      if (w_tx_hs) begin
        r_tx_shift   <= i_tx_data;
        r_tx_par_en  <= parity_en(i_parity_mode);
        r_tx_par_bit <= parity_bit(9'(i_tx_data), i_parity_mode);
      end else if (r_tx_state == TX_DATA && w_tx_tick) begin
        r_tx_shift <= r_tx_shift >> 1;
      end
      r_tx_bit_cnt  <= (r_tx_state == TX_DATA) ? r_tx_bit_cnt + (w_tx_tick ? 4'd1 : 4'd0) : '0;
      r_tx_stop_cnt <= (r_tx_state == TX_STOP) ? r_tx_stop_cnt + (w_tx_tick ? 2'd1 : 2'd0) : '0;
    end
  end

  // ---------------- receive path ----------------
  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_rx_prev, r_rx_par_en, r_rx_perr_pend;
  logic [1:0]           r_rx_mode;
  logic [3:0]           r_rx_bit_cnt;
  logic [DATA_BITS-1:0] r_rx_shift, r_rx_data;
  logic                 r_rx_valid, r_rx_parity_err, r_rx_frame_err;
  logic                 w_rx_src, w_rx_s, w_rx_fall, w_rx_tick, w_rx_load;

`ifdef UART_LOOPBACK_EN
  assign w_rx_src = i_loopback ? r_tx : i_rx;
  assign o_tx     = i_loopback ? 1'b1 : r_tx;
`else
  assign w_rx_src = i_rx;
  assign o_tx     = r_tx;
`endif

  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign w_rx_fall = r_rx_prev && !w_rx_s;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
    .clk(clk), .reset(reset), .i_load(w_rx_load), .i_half(1'b1), .o_tick(w_rx_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_state_nxt;
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_load      = 1'b0;
    unique case (r_rx_state)
      RX_IDLE:   if (w_rx_fall) begin
                   w_rx_state_nxt = RX_START;
                   w_rx_load      = 1'b1;
                 end
      RX_START:  if (w_rx_tick) w_rx_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_tick && r_rx_bit_cnt == 4'(DATA_BITS - 1))
                   w_rx_state_nxt = r_rx_par_en ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_tick) w_rx_state_nxt = RX_STOP;
      RX_STOP:   if (w_rx_tick) w_rx_state_nxt = w_rx_s ? RX_IDLE : RX_BREAK;
      RX_BREAK:  if (w_rx_s) w_rx_state_nxt = RX_IDLE;
      default:   w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync          <= '1;
      r_rx_prev       <= 1'b1;
      r_rx_mode       <= PAR_NONE;
      r_rx_par_en     <= 1'b0;
      r_rx_perr_pend  <= 1'b0;
      r_rx_bit_cnt    <= '0;
      r_rx_shift      <= '0;
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_rx_parity_err <= 1'b0;
      r_rx_frame_err  <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], w_rx_src};
      r_rx_prev  <= w_rx_s;
      r_rx_valid <= 1'b0;
      if (r_rx_state == RX_IDLE && w_rx_fall) begin
        r_rx_mode      <= i_parity_mode;
        r_rx_par_en    <= parity_en(i_parity_mode);
        r_rx_perr_pend <= 1'b0;
      end
      r_rx_bit_cnt <= (r_rx_state == RX_DATA) ? r_rx_bit_cnt + (w_rx_tick ? 4'd1 : 4'd0) : '0;
      if (w_rx_tick) begin
        unique case (r_rx_state)
          RX_DATA:   r_rx_shift <= {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
          RX_PARITY: r_rx_perr_pend <= (w_rx_s != parity_bit(9'(r_rx_shift), r_rx_mode));
          RX_STOP: begin
            r_rx_valid      <= 1'b1;
            r_rx_data       <= r_rx_shift;
            r_rx_parity_err <= r_rx_par_en && r_rx_perr_pend;
            r_rx_frame_err  <= !w_rx_s;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_rx_data       = r_rx_data;
  assign o_rx_valid      = r_rx_valid;
  assign o_rx_parity_err = r_rx_parity_err;
  assign o_rx_frame_err  = r_rx_frame_err;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench: frame-level tx/rx model compared every cycle, plus literal pins.
module tb_uart_transceiver;

  localparam int DB  = 8;
  localparam int CPB = 16;
  localparam int SB  = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_perr, rx_ferr;

  uart_transceiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .i_parity_mode(mode), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .o_tx(tx), .i_rx(rx), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_rx_parity_err(rx_perr), .o_rx_frame_err(rx_ferr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected parity bit so that the total count of ones matches the mode.
  function automatic bit good_par(input logic [DB-1:0] d, input logic [1:0] md);
    int ones;
    ones = $countones(d);
    return (md == 2'b10) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  // ---------------- frame-level model ----------------
  typedef struct packed { logic [DB-1:0] d; logic pe; logic fe; } rxw_t;

  bit   m_known = 1'b0;
  int   m_pos = -1;
  int   m_len = 0;
  int   m_n;
  bit   m_bits [0:15];
  rxw_t rxq [$];
  rxw_t c_e;
  logic [DB-1:0] last_d = '0;
  logic last_pe = 1'b0, last_fe = 1'b0;
  int   nvalid = 0;
  bit   c_exp_tx, c_exp_rdy;

  always @(negedge clk) begin : cmp
    if (m_known) begin
      c_exp_rdy = (m_pos < 0) || (m_pos == m_len - 1);
      c_exp_tx  = (m_pos < 0) ? 1'b1 : m_bits[m_pos / CPB];
      chk("tx_line", tx, c_exp_tx);
      chk("tx_ready", tx_ready, c_exp_rdy);
      if (rx_valid !== 1'b0) begin
        nvalid = nvalid + 1;
        if (rxq.size() == 0) chk("rx_spurious_valid", rx_valid, 1'b0);
        else begin
          c_e = rxq.pop_front();
          last_d = c_e.d; last_pe = c_e.pe; last_fe = c_e.fe;
        end
      end
      chk("rx_data", rx_data, last_d);
      chk("rx_parity_err", rx_perr, last_pe);
      chk("rx_frame_err", rx_ferr, last_fe);
    end
    if (reset === 1'b0) begin
      m_known = 1'b1; m_pos = -1;
      rxq.delete();
      last_d = '0; last_pe = 1'b0; last_fe = 1'b0;
    end else if (m_known) begin
      c_exp_rdy = (m_pos < 0) || (m_pos == m_len - 1);
      if (tx_valid && c_exp_rdy) begin
        m_n = 0;
        m_bits[m_n] = 1'b0; m_n = m_n + 1;
        for (int i = 0; i < DB; i++) begin m_bits[m_n] = tx_data[i]; m_n = m_n + 1; end
        if (mode == 2'b01 || mode == 2'b10) begin m_bits[m_n] = good_par(tx_data, mode); m_n = m_n + 1; end
        for (int s = 0; s < SB; s++) begin m_bits[m_n] = 1'b1; m_n = m_n + 1; end
        m_len = m_n * CPB;
        m_pos = 0;
      end else if (m_pos >= 0) begin
        m_pos = m_pos + 1;
        if (m_pos == m_len) m_pos = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic at_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_ready(output int hs);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("tx_handshake_timeout", tx_ready, 1'b1);
    hs = cyc;
  endtask

  task automatic tx_send(input logic [DB-1:0] d, output int hs);
    tx_data = d; tx_valid = 1'b1;
    wait_ready(hs);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic rx_frame(input logic [DB-1:0] d, input logic [1:0] md, input bit pb,
                          input bit stop_v, input int stop_len);
    rxw_t e;
    bit has_p;
    has_p = (md == 2'b01) || (md == 2'b10);
    e.d = d; e.pe = has_p && (pb != good_par(d, md)); e.fe = !stop_v;
    rxq.push_back(e);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < DB; i++) begin rx = d[i]; tick(CPB); end
    if (has_p) begin rx = pb; tick(CPB); end
    rx = stop_v; tick(stop_len);
    rx = 1'b1; tick(2);
    chk("rx_frame_delivered", rxq.size(), 0);
  endtask

  task automatic tx_rand(input int n);
    int hs;
    repeat (n) begin
      tick($urandom_range(0, 30));
      tx_send(DB'($urandom), hs);
    end
  endtask

  task automatic rx_rand(input int n);
    logic [DB-1:0] d;
    bit flip, sv;
    repeat (n) begin
      tick($urandom_range(0, 20));
      d    = DB'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      sv   = ($urandom_range(0, 5) != 0);
      rx_frame(d, mode, good_par(d, mode) ^ flip, sv, sv ? CPB : CPB + $urandom_range(0, 30));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  logic [7:0] a5_bits;
  int hs, hs1, hs2, n0;

  initial begin
    tick(2);
    reset = 1'b1;
    @(negedge clk);
    chk("t1_tx", tx, 1'b1);
    chk("t1_ready", tx_ready, 1'b1);
    chk("t1_rx_valid", rx_valid, 1'b0);
    chk("t1_perr", rx_perr, 1'b0);
    chk("t1_ferr", rx_ferr, 1'b0);
    tick(100);
    chk("t1_idle_tx", tx, 1'b1);

    // A5, no parity; mode flips mid-frame and must not add a parity bit.
    mode = 2'b00;
    tx_send(8'hA5, hs);
    mode = 2'b01;
    at_cyc(hs + 1);
    chk("t2_start_low", tx, 1'b0);
    chk("t2_ready_low", tx_ready, 1'b0);
    a5_bits = 8'b1010_0101;
    for (int k = 0; k < 8; k++) begin
      at_cyc(hs + 1 + CPB * (k + 1) + CPB / 2);
      chk("t2_data_bit", tx, a5_bits[k]);
    end
    at_cyc(hs + 1 + CPB * 9 + CPB / 2);
    chk("t2_stop_high", tx, 1'b1);
    at_cyc(hs + 159);
    chk("t2_ready_c159", tx_ready, 1'b0);
    at_cyc(hs + 160);
    chk("t2_ready_c160", tx_ready, 1'b1);
    @(posedge clk); #1;

    // Even/odd parity reception.
    n0 = nvalid;
    mode = 2'b01;
    rx_frame(8'h3C, 2'b01, 1'b0, 1'b1, CPB);
    chk("t3_even_count", nvalid - n0, 1);
    chk("t3_even_data", rx_data, 8'h3C);
    chk("t3_even_perr", rx_perr, 1'b0);
    mode = 2'b10;
    rx_frame(8'h3C, 2'b10, 1'b0, 1'b1, CPB);
    chk("t3_odd_data", rx_data, 8'h3C);
    chk("t3_odd_perr", rx_perr, 1'b1);

    // Break then recovery.
    mode = 2'b00;
    n0 = nvalid;
    rx_frame(8'h55, 2'b00, 1'b0, 1'b0, 40);
    chk("t4_break_count", nvalid - n0, 1);
    chk("t4_ferr", rx_ferr, 1'b1);
    tick(10);
    rx_frame(8'h6E, 2'b00, 1'b0, 1'b1, CPB);
    chk("t4_ferr_cleared", rx_ferr, 1'b0);

    // Glitch reject then a good frame.
    n0 = nvalid;
    rx = 1'b0; tick(5); rx = 1'b1; tick(40);
    chk("t5_glitch_no_valid", nvalid - n0, 0);
    rx_frame(8'h81, 2'b00, 1'b0, 1'b1, CPB);
    chk("t5_data", rx_data, 8'h81);
    chk("t5_count", nvalid - n0, 1);

    // Back-to-back transmit, then reset mid-frame.
    tx_data = 8'h01; tx_valid = 1'b1;
    wait_ready(hs1);
    @(posedge clk); #1;
    tx_data = 8'h02;
    wait_ready(hs2);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("t6_no_gap", hs2 - hs1, 160);
    at_cyc(hs2 + 1 + CPB * 4 + 5);
    chk("t6_bit3", tx, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t6_reset_tx", tx, 1'b1);
    chk("t6_reset_ready", tx_ready, 1'b1);
    reset = 1'b1;
    tick(20);

    // Randomised concurrent traffic, one parity mode per phase.
    for (int ph = 0; ph < 6; ph++) begin
      mode = 2'(ph % 4);
      tick(3);
      fork
        tx_rand(5);
        rx_rand(5);
      join
      tick(CPB * 14);
    end

    chk("final_rx_queue_empty", rxq.size(), 0);
    chk("final_tx_idle", tx, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
